// File: rtl/noc.sv
// 4x4 packet switch: per-input FIFOs, per-output arbitration, registered outputs.
// Define NOC_ROUND_ROBIN_EN for round-robin arbitration; fixed priority (input 0 highest) otherwise.
module noc #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              write0,
  input  logic              write1,
  input  logic              write2,
  input  logic              write3,
  input  logic [DATA_W-1:0] dataIn0,
  input  logic [DATA_W-1:0] dataIn1,
  input  logic [DATA_W-1:0] dataIn2,
  input  logic [DATA_W-1:0] dataIn3,
  output logic [DATA_W-1:0] dataOut0,
  output logic [DATA_W-1:0] dataOut1,
  output logic [DATA_W-1:0] dataOut2,
  output logic [DATA_W-1:0] dataOut3,
  output logic              full0,
  output logic              almost_full0,
  output logic              full1,
  output logic              almost_full1,
  output logic              full2,
  output logic              almost_full2,
  output logic              full3,
  output logic              almost_full3
);

  localparam logic [ADDR_W:0] FULL_CNT  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] AFULL_CNT = (ADDR_W+1)'(DEPTH - 1);

  logic [3:0]        wr;
  logic [DATA_W-1:0] din    [4];
  logic [DATA_W-1:0] mem_q  [4][DEPTH];
  logic [ADDR_W-1:0] wp_q   [4];
  logic [ADDR_W-1:0] rp_q   [4];
  logic [ADDR_W:0]   cnt_q  [4];
  logic [ADDR_W:0]   cnt_d  [4];
  logic [DATA_W-1:0] head   [4];
  logic [DATA_W-1:0] dout_q [4];
  logic [DATA_W-1:0] dout_d [4];
  logic [3:0]        req    [4];
  logic [3:0]        gnt    [4];
  logic [3:0]        full, afull, push, pop;
`ifdef NOC_ROUND_ROBIN_EN
  logic [1:0]        ptr_q  [4];
  logic [1:0]        ptr_d  [4];
`endif

  assign wr     = {write3, write2, write1, write0};
  assign din[0] = dataIn0;
  assign din[1] = dataIn1;
  assign din[2] = dataIn2;
  assign din[3] = dataIn3;

  always_comb begin
    full  = '0;
    afull = '0;
    push  = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      full[i]  = (cnt_q[i] == FULL_CNT);
      afull[i] = (cnt_q[i] >= AFULL_CNT);
      push[i]  = wr[i] & ~full[i] & din[i][0];
      head[i]  = mem_q[i][rp_q[i]];
    end
    for (int unsigned o = 0; o < 4; o++) begin
      req[o] = '0;
      for (int unsigned i = 0; i < 4; i++)
        req[o][2'(i)] = (cnt_q[i] != '0) && (head[i][2:1] == 2'(o));
    end
  end

  // Each head requests exactly one output, so at most one grant can pop a given FIFO.
  always_comb begin
    logic [1:0] idx;
    idx = '0;
    pop = '0;
    for (int unsigned o = 0; o < 4; o++) begin
      gnt[o]    = '0;
      dout_d[o] = '0;
`ifdef NOC_ROUND_ROBIN_EN
      ptr_d[o]  = ptr_q[o];
      for (int unsigned k = 0; k < 4; k++) begin
        idx = ptr_q[o] + 2'(k);
        if (gnt[o] == '0 && req[o][idx]) begin
          gnt[o][idx] = 1'b1;
          dout_d[o]   = head[idx];
          ptr_d[o]    = idx + 2'd1;
        end
      end
`else
      for (int unsigned k = 0; k < 4; k++) begin
        idx = 2'(k);
        if (gnt[o] == '0 && req[o][idx]) begin
          gnt[o][idx] = 1'b1;
          dout_d[o]   = head[idx];
        end
      end
`endif
      pop = pop | gnt[o];
    end
    for (int unsigned i = 0; i < 4; i++) begin
      case ({push[i], pop[i]})
        2'b10:   cnt_d[i] = cnt_q[i] + (ADDR_W+1)'(1);
        2'b01:   cnt_d[i] = cnt_q[i] - (ADDR_W+1)'(1);
        default: cnt_d[i] = cnt_q[i];
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < 4; i++) begin
        wp_q[i]   <= '0;
        rp_q[i]   <= '0;
        cnt_q[i]  <= '0;
        dout_q[i] <= '0;
`ifdef NOC_ROUND_ROBIN_EN
        ptr_q[i]  <= '0;
`endif
      end
    end else begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (push[i]) wp_q[i] <= wp_q[i] + ADDR_W'(1);
        if (pop[i])  rp_q[i] <= rp_q[i] + ADDR_W'(1);
        cnt_q[i]  <= cnt_d[i];
        dout_q[i] <= dout_d[i];
`ifdef NOC_ROUND_ROBIN_EN
        ptr_q[i]  <= ptr_d[i];
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < 4; i++)
      if (push[i] && !reset) mem_q[i][wp_q[i]] <= din[i];
  end

  assign dataOut0     = dout_q[0];
  assign dataOut1     = dout_q[1];
  assign dataOut2     = dout_q[2];
  assign dataOut3     = dout_q[3];
  assign full0        = full[0];
  assign almost_full0 = afull[0];
  assign full1        = full[1];
  assign almost_full1 = afull[1];
  assign full2        = full[2];
  assign almost_full2 = afull[2];
  assign full3        = full[3];
  assign almost_full3 = afull[3];

endmodule

// File: tb/tb_noc.sv
// Scoreboard bench for noc: a queue-based reference predicts every output word and FIFO flag.
module tb_noc;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_v  [4];
  logic [DW-1:0] din_v [4];
  logic [DW-1:0] dout  [4];
  logic          full_w[4];
  logic          af_w  [4];

  always #5 clk = ~clk;

  noc #(.DATA_W(16), .DEPTH(32), .ADDR_W(5)) dut (
    .clk(clk), .reset(rst),
    .write0(wr_v[0]), .write1(wr_v[1]), .write2(wr_v[2]), .write3(wr_v[3]),
    .dataIn0(din_v[0]), .dataIn1(din_v[1]), .dataIn2(din_v[2]), .dataIn3(din_v[3]),
    .dataOut0(dout[0]), .dataOut1(dout[1]), .dataOut2(dout[2]), .dataOut3(dout[3]),
    .full0(full_w[0]), .almost_full0(af_w[0]),
    .full1(full_w[1]), .almost_full1(af_w[1]),
    .full2(full_w[2]), .almost_full2(af_w[2]),
    .full3(full_w[3]), .almost_full3(af_w[3])
  );

  int n_chk = 0;
  int n_bad = 0;
  int seq   = 0;

  typedef struct {
    int            port;
    logic [DW-1:0] val;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] mq[4][$];
`ifdef NOC_ROUND_ROBIN_EN
  int            rr[4];
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] pkt(input int src, input int dest);
    logic [10:0] s;
    s = 11'(seq);
    seq++;
    return {s, 2'(src), 2'(dest), 1'b1};
  endfunction

  task automatic idle();
    for (int i = 0; i < 4; i++) begin
      wr_v[i]  = 1'b0;
      din_v[i] = '0;
    end
  endtask

  // One clock: predict next outputs from the pre-edge model, update model, then compare.
  task automatic tick();
    logic [DW-1:0] hv;
    logic          popf[4];
    logic          fullpre[4];
    int            g;
    int            c;
    exp_t          e;
    @(negedge clk);
    if (rst) begin
      for (int p = 0; p < 4; p++) begin
        mq[p].delete();
`ifdef NOC_ROUND_ROBIN_EN
        rr[p] = 0;
`endif
        sb.push_back('{p, '0});
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        popf[i]    = 1'b0;
        fullpre[i] = (mq[i].size() >= 32);
      end
      for (int o = 0; o < 4; o++) begin
        g = -1;
        for (int k = 0; k < 4; k++) begin
`ifdef NOC_ROUND_ROBIN_EN
          c = (rr[o] + k) % 4;
`else
          c = k;
`endif
          if (g < 0 && mq[c].size() > 0) begin
            hv = mq[c][0];
            if (int'(hv[2:1]) == o) g = c;
          end
        end
        if (g >= 0) begin
          sb.push_back('{o, mq[g][0]});
          popf[g] = 1'b1;
`ifdef NOC_ROUND_ROBIN_EN
          rr[o] = (g + 1) % 4;
`endif
        end else begin
          sb.push_back('{o, '0});
        end
      end
      for (int i = 0; i < 4; i++) begin
        if (popf[i]) void'(mq[i].pop_front());
        if (wr_v[i] && !fullpre[i] && din_v[i][0]) mq[i].push_back(din_v[i]);
      end
    end
    @(posedge clk);
    #1;
    for (int o = 0; o < 4; o++) begin
      if (sb.size() == 0) begin
        check("sb_underflow", 32'(0), 32'(1));
      end else begin
        e = sb.pop_front();
        check($sformatf("dout%0d", e.port), 32'(dout[e.port]), 32'(e.val));
      end
    end
    for (int i = 0; i < 4; i++) begin
      check($sformatf("full%0d", i), 32'(full_w[i]), 32'(mq[i].size() >= 32));
      check($sformatf("afull%0d", i), 32'(af_w[i]), 32'(mq[i].size() >= 31));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    idle();
    tick();
    tick();
    check("rst_dout2", 32'(dout[2]), 32'(0));
    check("rst_full0", 32'(full_w[0]), 32'(0));
    rst = 1'b0;
    tick();

    // single packet 0 -> 2
    wr_v[0] = 1'b1;
    din_v[0] = 16'h0005;
    tick();
    idle();
    tick();
    check("single_hit", 32'(dout[2]), 32'(16'h0005));
    tick();
    check("single_clear", 32'(dout[2]), 32'(0));

    // invalid word discarded
    wr_v[1] = 1'b1;
    din_v[1] = 16'h0002;
    tick();
    idle();
    tick();
    check("invalid_drop", 32'(dout[0]), 32'(0));

    // all ports hammer output 2 until FIFOs saturate, then drain
    for (int n = 0; n < 60; n++) begin
      for (int i = 0; i < 4; i++) begin
        wr_v[i]  = 1'b1;
        din_v[i] = pkt(i, 2);
      end
      tick();
    end
    check("sat_afull3", 32'(af_w[3]), 32'(1));
    idle();
    for (int n = 0; n < 140; n++) tick();
    check("drained_full3", 32'(full_w[3]), 32'(0));
    check("drained_dout2", 32'(dout[2]), 32'(0));

    // crossing traffic: every output busy each cycle
    for (int n = 0; n < 20; n++) begin
      wr_v[0] = 1'b1; din_v[0] = pkt(0, 1);
      wr_v[1] = 1'b1; din_v[1] = pkt(1, 0);
      wr_v[2] = 1'b1; din_v[2] = pkt(2, 3);
      wr_v[3] = 1'b1; din_v[3] = pkt(3, 2);
      tick();
    end
    check("cross_d1_valid", 32'(dout[1][0]), 32'(1));
    check("cross_afull0", 32'(af_w[0]), 32'(0));
    idle();
    for (int n = 0; n < 3; n++) tick();

    // reset mid-traffic
    for (int n = 0; n < 10; n++) begin
      for (int i = 0; i < 4; i++) begin
        wr_v[i]  = 1'b1;
        din_v[i] = pkt(i, 0);
      end
      tick();
    end
    rst = 1'b1;
    tick();
    check("midrst_dout0", 32'(dout[0]), 32'(0));
    rst = 1'b0;
    idle();
    for (int n = 0; n < 5; n++) tick();

    // ports 0 and 3 competing for output 1
    for (int n = 0; n < 10; n++) begin
      wr_v[0] = 1'b1; din_v[0] = pkt(0, 1);
      wr_v[3] = 1'b1; din_v[3] = pkt(3, 1);
      tick();
    end
    idle();
    for (int n = 0; n < 30; n++) tick();

    // random traffic including invalid words
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 4; i++) begin
        wr_v[i]  = 1'($urandom_range(0, 1));
        din_v[i] = pkt(i, int'($urandom_range(0, 3)));
        if ($urandom_range(0, 3) == 0) din_v[i][0] = 1'b0;
      end
      tick();
    end
    idle();
    for (int n = 0; n < 150; n++) tick();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
